// File: rtl/register_file_pkg.sv
// Shared defaults for the 16-bit datapath register file.
package register_file_pkg;

    localparam int unsigned DATA_W_DEF   = 16;
    localparam int unsigned ADDR_W_DEF   = 4;
    localparam int unsigned NUM_REGS_DEF = 16;

    // Value every register takes while RSTn is low.
    localparam logic [DATA_W_DEF-1:0] RESET_VAL = '0;

endpackage

// File: rtl/register_file.sv
// General-purpose register file: two combinational read ports and one
// synchronous write port that shares its address with the DEST read port.
//
// Ports
//   CLK      clock, rising edge active
//   RSTn     asynchronous active-low reset, clears every register
//   ADDR_A   read address for SRC
//   ADDR_B   read address for DEST, also the write address
//   DATA_IN  write data
//   WR       write enable, sampled on rising CLK
//   SRC      reg_array[ADDR_A], 0 when ADDR_A is out of range
//   DEST     reg_array[ADDR_B], 0 when ADDR_B is out of range
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [ADDR_W-1:0] ADDR_A,
    input  logic [ADDR_W-1:0] ADDR_B,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              WR,
    output logic [DATA_W-1:0] SRC,
    output logic [DATA_W-1:0] DEST
);

    logic [DATA_W-1:0] reg_array [0:NUM_REGS-1];
    logic [DATA_W-1:0] src_c;
    logic [DATA_W-1:0] dest_c;

    // Write port. Decoding by comparison against each implemented index means
    // an out-of-range ADDR_B matches nothing, so the write is dropped. An
    // unknown WR evaluates as false and is treated as no write.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                reg_array[i] <= DATA_W'(RESET_VAL);
            end
        end else if (WR) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (ADDR_B == ADDR_W'(i)) begin
                    reg_array[i] <= DATA_IN;
                end
            end
        end
    end

    // Read muxes; default 0 covers out-of-range addresses. No write bypass.
    always_comb begin
        src_c  = '0;
        dest_c = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (ADDR_A == ADDR_W'(i)) begin
                src_c = reg_array[i];
            end
            if (ADDR_B == ADDR_W'(i)) begin
                dest_c = reg_array[i];
            end
        end
    end

    assign SRC  = src_c;
    assign DEST = dest_c;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file. A reference array tracks what each
// register should hold; expected values are queued when stimulus is applied
// and popped against the DUT once its outputs have settled.
module tb_register_file;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned NREGS = 12;  // leaves addresses 12..15 out of range

    typedef struct {
        string         tag;
        logic [DW-1:0] exp;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] data_in;
    logic          wr;
    logic [DW-1:0] src;
    logic [DW-1:0] dest;

    logic [DW-1:0] model [0:NREGS-1];
    exp_t          sb [$];
    int            checks;
    int            errors;

    register_file #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_REGS (NREGS)
    ) dut (
        .CLK     (clk),
        .RSTn    (rst_n),
        .ADDR_A  (addr_a),
        .ADDR_B  (addr_b),
        .DATA_IN (data_in),
        .WR      (wr),
        .SRC     (src),
        .DEST    (dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (32'(a) < NREGS) return model[a];
        return '0;
    endfunction

    task automatic expect_val(input string tag, input logic [DW-1:0] v);
        sb.push_back('{tag: tag, exp: v});
    endtask

    task automatic compare_next(input logic [DW-1:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty: observed %h with no expected value queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic check_ports(input string tag);
        expect_val({tag, "_src"}, model_read(addr_a));
        expect_val({tag, "_dest"}, model_read(addr_b));
        compare_next(src);
        compare_next(dest);
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < NREGS; i++) expect_val($sformatf("%s_r%0d", tag, i), model[i]);
        for (int i = 0; i < NREGS; i++) compare_next(dut.reg_array[i]);
    endtask

    // Write through the DEST address; DEST must show the old value before the
    // edge and the new one just after it.
    task automatic do_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        addr_b  = a;
        data_in = d;
        wr      = 1'b1;
        #1;
        expect_val({tag, "_pre"}, model_read(a));
        compare_next(dest);
        @(posedge clk);
        #1;
        wr = 1'b0;
        if (32'(a) < NREGS) model[a] = d;
        expect_val({tag, "_post"}, model_read(a));
        compare_next(dest);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        addr_a  = '0;
        addr_b  = '0;
        data_in = '0;
        wr      = 1'b0;
        for (int i = 0; i < NREGS; i++) model[i] = '0;

        // Reset for 20 ns, then release.
        #20;
        rst_n = 1'b1;
        #1;
        check_all_regs("reset");
        check_ports("reset");

        // Single writes to R1 and R7.
        do_write("wr_r1", 4'd1, 16'h1234);
        check_all_regs("after_r1");
        do_write("wr_r7", 4'd7, 16'h5678);
        check_all_regs("after_r7");

        // Combinational reads, no clock edge between address changes.
        @(negedge clk);
        addr_a = 4'd4;
        addr_b = 4'd5;
        #1 check_ports("rd_4_5");
        addr_a = 4'd7;
        #1 check_ports("rd_a7");
        addr_b = 4'd1;
        #1 check_ports("rd_b1");
        addr_b = 4'd7;
        #1 check_ports("rd_same");

        // WR low for several edges: nothing changes.
        @(negedge clk);
        addr_b  = 4'd3;
        data_in = 16'hBEEF;
        wr      = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all_regs("wr_low");

        // Unknown WR counts as no write.
        @(negedge clk);
        data_in = 16'hDEAD;
        wr      = 1'bx;
        @(posedge clk);
        #1 wr = 1'b0;
        check_all_regs("wr_x");

        // R0 and the last implemented register are ordinary.
        do_write("wr_r0", 4'd0, 16'hA5A5);
        do_write("wr_last", 4'(NREGS - 1), 16'h0F0F);
        check_all_regs("after_edges");

        // Out-of-range write is dropped and out-of-range reads return 0.
        do_write("wr_oor", 4'd13, 16'hFFFF);
        check_all_regs("after_oor");
        @(negedge clk);
        addr_a = 4'd15;
        addr_b = 4'(NREGS);
        #1 check_ports("rd_oor");

        // Back-to-back writes to the same register.
        do_write("wr_r3a", 4'd3, 16'h1111);
        do_write("wr_r3b", 4'd3, 16'h2222);

        // Asynchronous reset mid-cycle clears everything before the next edge.
        @(negedge clk);
        addr_a = 4'd7;
        addr_b = 4'd1;
        #1 check_ports("pre_rst");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        check_all_regs("async_rst");
        check_ports("async_rst");

        // Reset dominates a write request.
        wr      = 1'b1;
        addr_b  = 4'd2;
        data_in = 16'hCAFE;
        @(posedge clk);
        #1 check_all_regs("rst_over_wr");
        wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_ports("post_rst");

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
